// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Contents:
//   REQ_ADDR_WIDTH, REQ_DATA_WIDTH, MEM_OP_SIZE - operation field widths
//   mem_op_t    - packed {byte_en, addr, data} operation / response word
//   client_id_t - requester identifier (0 or 1)
//   op_is_read  - true when an operation carries no byte enables
package mem_arb_pkg;

    localparam int unsigned REQ_ADDR_WIDTH = 32;
    localparam int unsigned REQ_DATA_WIDTH = 32;
    localparam int unsigned MEM_OP_SIZE    = 68;

    typedef struct packed {
        logic [3:0]                byte_en;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] data;
    } mem_op_t;

    typedef logic client_id_t;

    function automatic logic op_is_read(input mem_op_t op);
        return op.byte_en == 4'b0000;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Owner-ID FIFO: records which requester issued each accepted memory op so
// responses can be routed back in issue order.
// Ports:
//   clk_i, rst_i       - clock, synchronous active-high reset
//   push_i, push_id_i  - enqueue an owner ID
//   pop_i              - dequeue the head entry
//   head_o             - owner ID at the head
//   full_o, empty_o    - occupancy flags
//   count_o            - current occupancy
// Push and pop in the same cycle are legal at any occupancy, including full.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  client_id_t      push_id_i,
    input  logic            pop_i,
    output client_id_t      head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // Pointers wrap modulo Depth; the separate counter disambiguates full/empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // The arbiter never pops an empty FIFO or overfills it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(pop_i && empty_o));
            assert (!(push_i && full_o && !pop_i));
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto one BRAM read/write port and routes
// responses back to their owner in issue order via an owner-ID FIFO.
// Ports:
//   clk_i, rst_i                  - clock, synchronous active-high reset
//                                   (drive the BRAM RST_N from !rst_i)
//   req_valid{0,1}_i, req{0,1}_i  - requester op channels
//   req_ready{0,1}_o              - op accepted when high with valid
//   rsp_valid{0,1}_o, rsp{0,1}_o  - response channels (data shared)
//   rsp_ready{0,1}_i              - requester takes the response
//   mem_put_*                     - op channel to the memory
//   mem_get_*                     - response channel from the memory
//   outstanding_o                 - accepted ops awaiting a response
// Configuration macro:
//   MEM_ARB_FIXED_PRIO_EN - requester 0 always wins ties (no round-robin
//                           state); requester 1 can starve.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   req_valid0_i,
    input  mem_op_t                                req0_i,
    output logic                                   req_ready0_o,
    input  logic                                   req_valid1_i,
    input  mem_op_t                                req1_i,
    output logic                                   req_ready1_o,
    output logic                                   rsp_valid0_o,
    output mem_op_t                                rsp0_o,
    input  logic                                   rsp_ready0_i,
    output logic                                   rsp_valid1_o,
    output mem_op_t                                rsp1_o,
    input  logic                                   rsp_ready1_i,
    output logic                                   mem_put_valid_o,
    output mem_op_t                                mem_put_request_o,
    input  logic                                   mem_put_ready_i,
    output logic                                   mem_get_valid_o,
    input  mem_op_t                                mem_get_response_i,
    input  logic                                   mem_get_ready_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    client_id_t grant;
    client_id_t owner;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       put_fire;
    logic       can_issue_base;
    logic       rsp_present;

    // ---------------------------------------------------------------------
    // Grant selection. Independent of mem_put_ready_i so the request mux is
    // stable while the memory decides whether to accept.
    // ---------------------------------------------------------------------
`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = client_id_t'(!req_valid0_i && req_valid1_i);
    end
`else
    client_id_t last_grant_q, last_grant_d;

    always_comb begin
        if (req_valid0_i && req_valid1_i) begin
            grant = ~last_grant_q;
        end else begin
            grant = client_id_t'(req_valid1_i);
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (put_fire) begin
            last_grant_d = grant;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Issue side. A pop in the same cycle frees a slot, so a full FIFO can
    // still accept when its head response is being consumed.
    // ---------------------------------------------------------------------
    assign can_issue_base    = !rst_i && (!fifo_full || fifo_pop);
    assign mem_put_valid_o   = can_issue_base && (req_valid0_i || req_valid1_i);
    assign mem_put_request_o = grant ? req1_i : req0_i;
    assign req_ready0_o      = mem_put_ready_i && can_issue_base && (grant == 1'b0);
    assign req_ready1_o      = mem_put_ready_i && can_issue_base && (grant == 1'b1);
    assign put_fire          = mem_put_valid_o && mem_put_ready_i;

    // ---------------------------------------------------------------------
    // Response side. Gated by reset so nothing leaks out of a FIFO that is
    // being cleared this cycle.
    // ---------------------------------------------------------------------
    assign rsp_present     = !rst_i && !fifo_empty;
    assign rsp_valid0_o    = mem_get_ready_i && rsp_present && (owner == 1'b0);
    assign rsp_valid1_o    = mem_get_ready_i && rsp_present && (owner == 1'b1);
    assign rsp0_o          = mem_get_response_i;
    assign rsp1_o          = mem_get_response_i;
    assign mem_get_valid_o = rsp_present && (owner ? rsp_ready1_i : rsp_ready0_i);
    assign fifo_pop        = mem_get_valid_o && mem_get_ready_i;

    mem_arb_id_fifo #(
        .Depth(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (put_fire),
        .push_id_i(grant),
        .pop_i    (fifo_pop),
        .head_o   (owner),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (outstanding_o)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small BRAM model that accepts
// up to two pending ops and presents each response one cycle after issue.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_mem;
    logic       req_valid0, req_valid1, req_ready0, req_ready1;
    mem_op_t    req0, req1, rsp0, rsp1;
    logic       rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
    logic       mem_put_valid, mem_put_ready, mem_get_valid, mem_get_ready;
    mem_op_t    mem_put_request, mem_get_response;
    logic [1:0] outstanding;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid0_i      (req_valid0),
        .req0_i            (req0),
        .req_ready0_o      (req_ready0),
        .req_valid1_i      (req_valid1),
        .req1_i            (req1),
        .req_ready1_o      (req_ready1),
        .rsp_valid0_o      (rsp_valid0),
        .rsp0_o            (rsp0),
        .rsp_ready0_i      (rsp_ready0),
        .rsp_valid1_o      (rsp_valid1),
        .rsp1_o            (rsp1),
        .rsp_ready1_i      (rsp_ready1),
        .mem_put_valid_o   (mem_put_valid),
        .mem_put_request_o (mem_put_request),
        .mem_put_ready_i   (mem_put_ready),
        .mem_get_valid_o   (mem_get_valid),
        .mem_get_response_i(mem_get_response),
        .mem_get_ready_i   (mem_get_ready),
        .outstanding_o     (outstanding)
    );

    // ---------------- BRAM model (reset from the same RST) ----------------
    logic [31:0] mem [0:255];
    mem_op_t     rq0, rq1;
    int          rcnt;

    assign mem_get_ready    = (rcnt != 0);
    assign mem_get_response = rq0;
    assign mem_put_ready    = (rcnt < 2) || mem_get_valid;

    always @(posedge clk) begin
        logic    pop, push;
        mem_op_t r;
        pop  = mem_get_valid && mem_get_ready;
        push = mem_put_valid && mem_put_ready;
        r    = mem_put_request;
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[8'h10] <= 32'hDEAD_BEEF;
            mem[8'h20] <= 32'hFFFF_FFFF;
        end
        if (rst) begin
            rcnt <= 0;
        end else begin
            if (push) begin
                if (r.byte_en == 4'b0000) begin
                    r.data = mem[r.addr[9:2]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (r.byte_en[b]) mem[r.addr[9:2]][8*b +: 8] <= r.data[8*b +: 8];
                    r.data = 32'h0;
                end
            end
            if (push && pop) begin
                if (rcnt == 1) rq0 <= r;
                else begin rq0 <= rq1; rq1 <= r; end
            end else if (pop) begin
                rq0  <= rq1;
                rcnt <= rcnt - 1;
            end else if (push) begin
                if (rcnt == 0) rq0 <= r;
                else rq1 <= r;
                rcnt <= rcnt + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        req0       = '0;
        req1       = '0;
        rsp_ready0 = 1'b1;
        rsp_ready1 = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst        = 1'b1;
        init_mem   = 1'b1;
        idle_inputs();
        req_valid0 = 1'b1;
        req_valid1 = 1'b1;
        tick();
        @(negedge clk);
        vectors++;
        if ({req_ready0, req_ready1, mem_put_valid, mem_get_valid, rsp_valid0, rsp_valid1}
            !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b exp 000000",
                     {req_ready0, req_ready1, mem_put_valid, mem_get_valid,
                      rsp_valid0, rsp_valid1});
        end
        tick();
        rst      = 1'b0;
        init_mem = 1'b0;
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (outstanding !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_outstanding: got %0d exp 0", outstanding);
        end
        tick();
    endtask

    // Both requesters valid every cycle: grants alternate 0,1,... one per cycle.
    task automatic test_contention();
        logic prev;
        req0       = '{byte_en: 4'h0, addr: 32'h200, data: 32'h0};
        req1       = '{byte_en: 4'h0, addr: 32'h300, data: 32'h0};
        req_valid0 = 1'b1;
        req_valid1 = 1'b1;
        prev       = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic exp_g;
            exp_g = k[0];
            @(negedge clk);
            vectors++;
            if ({mem_put_valid, req_ready0, req_ready1} !== {1'b1, !exp_g, exp_g}) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: got put/r0/r1=%b exp %b", k,
                         {mem_put_valid, req_ready0, req_ready1}, {1'b1, !exp_g, exp_g});
            end
            if (k > 0) begin
                vectors++;
                if ({rsp_valid0, rsp_valid1} !== {!prev, prev} ||
                    rsp0.data !== (prev ? 32'hA500_00C0 : 32'hA500_0080)) begin
                    miscompares++;
                    $display("FAIL contention_rsp[%0d]: got v=%b data=%h exp v=%b data=%h",
                             k, {rsp_valid0, rsp_valid1}, rsp0.data, {!prev, prev},
                             prev ? 32'hA500_00C0 : 32'hA500_0080);
                end
            end
            prev = exp_g;
            tick();
        end
        idle_inputs();
        tick();
        @(negedge clk);
        vectors++;
        if (outstanding !== 2'd0) begin
            miscompares++;
            $display("FAIL contention_drain: got %0d exp 0", outstanding);
        end
        tick();
    endtask

    task automatic test_single_read();
        req0       = '{byte_en: 4'h0, addr: 32'h40, data: 32'h0};
        req_valid0 = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_ready0, mem_put_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL single_read_accept: got %b exp 11", {req_ready0, mem_put_valid});
        end
        tick();
        req_valid0 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rsp_valid0, rsp_valid1} !== 2'b10 || rsp0.data !== 32'hDEAD_BEEF ||
            outstanding !== 2'd1) begin
            miscompares++;
            $display("FAIL single_read_rsp: got v=%b data=%h out=%0d exp v=10 data=deadbeef out=1",
                     {rsp_valid0, rsp_valid1}, rsp0.data, outstanding);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid0 !== 1'b0 || outstanding !== 2'd0) begin
            miscompares++;
            $display("FAIL single_read_done: got v=%b out=%0d exp v=0 out=0",
                     rsp_valid0, outstanding);
        end
        tick();
    endtask

    task automatic test_write_read();
        req1       = '{byte_en: 4'b0011, addr: 32'h80, data: 32'h1234_ABCD};
        req_valid1 = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_ready0, req_ready1} !== 2'b01 || mem_put_request.addr !== 32'h80) begin
            miscompares++;
            $display("FAIL write_accept: got r=%b addr=%h exp r=01 addr=80",
                     {req_ready0, req_ready1}, mem_put_request.addr);
        end
        tick();
        req_valid1 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rsp_valid0, rsp_valid1} !== 2'b01 || rsp1.data !== 32'h0 ||
            rsp1.byte_en !== 4'b0011) begin
            miscompares++;
            $display("FAIL write_rsp: got v=%b data=%h be=%b exp v=01 data=0 be=0011",
                     {rsp_valid0, rsp_valid1}, rsp1.data, rsp1.byte_en);
        end
        tick();
        req0       = '{byte_en: 4'h0, addr: 32'h80, data: 32'h0};
        req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        @(negedge clk);
        vectors++;
        if (rsp_valid0 !== 1'b1 || rsp0.data !== 32'hFFFF_ABCD) begin
            miscompares++;
            $display("FAIL read_after_write: got v=%b data=%h exp v=1 data=ffffabcd",
                     rsp_valid0, rsp0.data);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        int puts;
        puts       = 0;
        rsp_ready0 = 1'b0;
        req_valid0 = 1'b1;
        req0       = '{byte_en: 4'h0, addr: 32'h40, data: 32'h0};
        tick();
        puts++;
        req0 = '{byte_en: 4'h0, addr: 32'h200, data: 32'h0};
        tick();
        puts++;
        req_valid0 = 1'b0;
        req_valid1 = 1'b1;
        req1       = '{byte_en: 4'h0, addr: 32'h300, data: 32'h0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_put_valid && mem_put_ready) puts++;
            vectors++;
            if ({req_ready1, mem_put_valid, mem_get_valid, rsp_valid0} !== 4'b0001 ||
                outstanding !== 2'd2) begin
                miscompares++;
                $display("FAIL bp_stall[%0d]: got r1/put/get/rv0=%b out=%0d exp 0001 out=2",
                         k, {req_ready1, mem_put_valid, mem_get_valid, rsp_valid0},
                         outstanding);
            end
            tick();
        end
        vectors++;
        if (puts !== 2) begin
            miscompares++;
            $display("FAIL bp_put_count: got %0d exp 2", puts);
        end
        rsp_ready0 = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_ready1, mem_get_valid} !== 2'b11 || rsp0.data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL bp_release: got r1/get=%b data=%h exp 11 data=deadbeef",
                     {req_ready1, mem_get_valid}, rsp0.data);
        end
        tick();
        req_valid1 = 1'b0;
        @(negedge clk);
        vectors++;
        if (rsp_valid0 !== 1'b1 || rsp0.data !== 32'hA500_0080 || outstanding !== 2'd2) begin
            miscompares++;
            $display("FAIL bp_order2: got v=%b data=%h out=%0d exp v=1 data=a5000080 out=2",
                     rsp_valid0, rsp0.data, outstanding);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({rsp_valid0, rsp_valid1} !== 2'b01 || rsp1.data !== 32'hA500_00C0 ||
            outstanding !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_order3: got v=%b data=%h out=%0d exp v=01 data=a50000c0 out=1",
                     {rsp_valid0, rsp_valid1}, rsp1.data, outstanding);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        rsp_ready0 = 1'b0;
        req_valid0 = 1'b1;
        req0       = '{byte_en: 4'h0, addr: 32'h40, data: 32'h0};
        tick();
        req_valid0 = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        vectors++;
        if ({outstanding, rsp_valid0, mem_put_valid} !== {2'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midflight_in_reset: got out=%0d rv0=%b put=%b exp out=1 rv0=0 put=0",
                     outstanding, rsp_valid0, mem_put_valid);
        end
        tick();
        rst        = 1'b0;
        rsp_ready0 = 1'b1;
        req_valid0 = 1'b1;
        req_valid1 = 1'b1;
        req1       = '{byte_en: 4'h0, addr: 32'h300, data: 32'h0};
        @(negedge clk);
        vectors++;
        if ({outstanding, rsp_valid0, rsp_valid1, req_ready0, req_ready1} !==
            {2'd0, 4'b0010}) begin
            miscompares++;
            $display("FAIL midflight_after: got out=%0d rv=%b r=%b exp out=0 rv=00 r=10",
                     outstanding, {rsp_valid0, rsp_valid1}, {req_ready0, req_ready1});
        end
        tick();
        @(negedge clk);
        vectors++;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if ({req_ready0, req_ready1} !== 2'b10) begin
`else
        if ({req_ready0, req_ready1} !== 2'b01) begin
`endif
            miscompares++;
            $display("FAIL midflight_second_grant: got r=%b", {req_ready0, req_ready1});
        end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

`ifdef MEM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        int g0;
        g0         = 0;
        req0       = '{byte_en: 4'h0, addr: 32'h200, data: 32'h0};
        req1       = '{byte_en: 4'h0, addr: 32'h300, data: 32'h0};
        req_valid0 = 1'b1;
        req_valid1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready0 && mem_put_valid) g0++;
            tick();
        end
        vectors++;
        if (g0 !== 10) begin
            miscompares++;
            $display("FAIL fixed_prio_grants: got %0d exp 10", g0);
        end
        idle_inputs();
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
`ifdef MEM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
`endif
        test_single_read();
        test_write_read();
        test_back_pressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
